// File: rtl/dmem_responder_if.sv
// Data-memory bus from the core memory stage, plus the GPIO value and the
// valid/ready byte stream that drains the TX FIFO.
interface dmem_responder_if;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic [31:0] gpio_out;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;

  // Core / consumer side.
  modport master (
    output MemWriteM, ALUResultM, WriteDataM, out_ready,
    input  ReadDataM, gpio_out, out_valid, out_data
  );

  // Responder side.
  modport slave (
    input  MemWriteM, ALUResultM, WriteDataM, out_ready,
    output ReadDataM, gpio_out, out_valid, out_data
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, GPIO, free-running cycle counter and a
// byte TX FIFO with sticky overflow status. Reads are combinational, writes
// commit on the rising edge. RAM contents deliberately survive reset.
module dmem_responder #(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [31:0] GPIO_ADDR   = 32'h8000_0000;
  localparam logic [31:0] CYCLE_ADDR  = 32'h8000_0004;
  localparam logic [31:0] TXDATA_ADDR = 32'h8000_0008;
  localparam logic [31:0] TXSTAT_ADDR = 32'h8000_000C;

  // Decode
  logic [31:0]   word_addr_s;
  logic [AW-1:0] ram_idx_s;
  logic          ram_sel_s;
  logic          gpio_sel_s;
  logic          cycle_sel_s;
  logic          txdata_sel_s;
  logic          txstat_sel_s;

  // Storage
  logic [31:0]   ram_r [RAM_WORDS];
  logic [31:0]   gpio_r;
  logic [31:0]   cycle_r;
  logic [7:0]    fifo_r [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          ovf_r;

  // FIFO control
  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic          pop_s;
  logic          push_ok_s;
  logic          drop_s;
  logic [7:0]    head_s;
  logic [7:0]    count8_s;

  logic [31:0]   rdata_s;

  // Address decode; the two byte-offset bits never take part.
  always_comb begin
    word_addr_s  = {bus.ALUResultM[31:2], 2'b00};
    ram_idx_s    = bus.ALUResultM[AW+1:2];
    ram_sel_s    = ((bus.ALUResultM >> (AW + 2)) == 32'h0000_0000);
    gpio_sel_s   = (word_addr_s == GPIO_ADDR);
    cycle_sel_s  = (word_addr_s == CYCLE_ADDR);
    txdata_sel_s = (word_addr_s == TXDATA_ADDR);
    txstat_sel_s = (word_addr_s == TXSTAT_ADDR);
  end

  // FIFO status and handshake; a push into a full FIFO is only accepted
  // when the head leaves on the same edge, otherwise it is dropped.
  always_comb begin
    empty_s   = (count_r == {CW{1'b0}});
    full_s    = (count_r == CW'(FIFO_DEPTH));
    push_s    = bus.MemWriteM & txdata_sel_s;
    pop_s     = ~empty_s & bus.out_ready;
    push_ok_s = push_s & (~full_s | pop_s);
    drop_s    = push_s & full_s & ~pop_s;
    count8_s  = 8'(count_r);
    if (empty_s) begin
      head_s = 8'h00;
    end else begin
      head_s = fifo_r[rd_ptr_r];
    end
  end

  // Combinational read mux for the current address; unmapped reads return 0.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (ram_sel_s) begin
      rdata_s = ram_r[ram_idx_s];
    end else begin
      case (word_addr_s)
        GPIO_ADDR:   rdata_s = gpio_r;
        CYCLE_ADDR:  rdata_s = cycle_r;
        TXDATA_ADDR: rdata_s = {24'h00_0000, head_s};
        TXSTAT_ADDR: rdata_s = {16'h0000, count8_s, 5'b0_0000, ovf_r, full_s, empty_s};
        default:     rdata_s = 32'h0000_0000;
      endcase
    end
  end

  assign bus.ReadDataM = rdata_s;
  assign bus.gpio_out  = gpio_r;
  assign bus.out_valid = ~empty_s;
  assign bus.out_data  = head_s;

  // RAM write port; no reset so contents persist across reset.
  always_ff @(posedge clk) begin
    if (bus.MemWriteM && ram_sel_s) begin
      ram_r[ram_idx_s] <= bus.WriteDataM;
    end
  end

  // GPIO register and cycle counter; a store to CYCLE wins over the increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_r  <= 32'h0000_0000;
      cycle_r <= 32'h0000_0000;
    end else begin
      if (bus.MemWriteM && gpio_sel_s) begin
        gpio_r <= bus.WriteDataM;
      end
      if (bus.MemWriteM && cycle_sel_s) begin
        cycle_r <= bus.WriteDataM;
      end else begin
        cycle_r <= cycle_r + 32'h0000_0001;
      end
    end
  end

  // FIFO byte storage; entries are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      fifo_r[wr_ptr_r] <= bus.WriteDataM[7:0];
    end
  end

  // FIFO pointers and occupancy; reset empties the FIFO asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow: set by a dropped push, cleared by any TXSTAT store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (bus.MemWriteM && txstat_sel_s) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic compared against a queue/array based reference model.
module tb_dmem_responder;
  localparam int RAM_WORDS  = 256;
  localparam int FIFO_DEPTH = 4;
  localparam logic [31:0] A_GPIO   = 32'h8000_0000;
  localparam logic [31:0] A_CYCLE  = 32'h8000_0004;
  localparam logic [31:0] A_TXDATA = 32'h8000_0008;
  localparam logic [31:0] A_TXSTAT = 32'h8000_000C;
  localparam logic [31:0] A_UNMAP  = 32'h8000_0010;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  dmem_responder_if bus();

  dmem_responder #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_ram [int];
  logic [31:0] m_gpio;
  logic [31:0] m_cycle;
  logic [7:0]  m_q [$];
  logic        m_ovf;

  logic [31:0] last_rd;
  logic        last_valid;
  logic [7:0]  last_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic ram_hit(input logic [31:0] a);
    return a < 32'(4 * RAM_WORDS);
  endfunction

  function automatic int ram_index(input logic [31:0] a);
    return int'(a / 32'd4);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (ram_hit(a)) return m_ram.exists(ram_index(a)) ? m_ram[ram_index(a)] : 32'h0;
    if (w == A_GPIO) return m_gpio;
    if (w == A_CYCLE) return m_cycle;
    if (w == A_TXDATA) return (m_q.size() > 0) ? {24'h0, m_q[0]} : 32'h0;
    if (w == A_TXSTAT)
      return {16'h0, 8'(m_q.size()), 5'h0, m_ovf, m_q.size() == FIFO_DEPTH, m_q.size() == 0};
    return 32'h0;
  endfunction

  function automatic void model_reset();
    m_gpio  = 32'h0;
    m_cycle = 32'h0;
    m_q.delete();
    m_ovf   = 1'b0;
  endfunction

  // One rising edge of the reference model, using pre-edge state.
  function automatic void model_clock(input logic we, input logic [31:0] a,
                                      input logic [31:0] wd, input logic rdy);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    m_cycle = m_cycle + 32'd1;
    if (we) begin
      if (ram_hit(a)) m_ram[ram_index(a)] = wd;
      else if (w == A_GPIO) m_gpio = wd;
      else if (w == A_CYCLE) m_cycle = wd;
      else if (w == A_TXDATA) begin
        if (m_q.size() < FIFO_DEPTH) m_q.push_back(wd[7:0]);
        else m_ovf = 1'b1;
      end
      else if (w == A_TXSTAT) m_ovf = 1'b0;
    end
  endfunction

  // Drive one cycle from just after a falling edge, check, clock, return.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic rdy, input string tag);
    bus.MemWriteM  = we;
    bus.ALUResultM = a;
    bus.WriteDataM = wd;
    bus.out_ready  = rdy;
    #1;
    last_rd    = bus.ReadDataM;
    last_valid = bus.out_valid;
    last_data  = bus.out_data;
    if (!ram_hit(a) || m_ram.exists(ram_index(a)))
      check({tag, "_rd"}, last_rd, model_read(a));
    check({tag, "_valid"}, {31'h0, last_valid}, {31'h0, m_q.size() != 0});
    check({tag, "_data"}, {24'h0, last_data}, (m_q.size() > 0) ? {24'h0, m_q[0]} : 32'h0);
    check({tag, "_gpio"}, bus.gpio_out, m_gpio);
    @(posedge clk);
    model_clock(we, a, wd, rdy);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] off;
    off = 32'($urandom_range(0, 3));
    case ($urandom_range(0, 9))
      0, 1, 2: return 32'($urandom_range(0, 63));
      3:       return A_GPIO | off;
      4:       return A_CYCLE | off;
      5, 6:    return A_TXDATA | off;
      7:       return A_TXSTAT | off;
      8:       return 32'h0000_03FC | off;
      default: begin
        case ($urandom_range(0, 3))
          0:       return 32'h0000_0400 | off;
          1:       return A_UNMAP | off;
          2:       return 32'h4000_0000;
          default: return 32'hFFFF_FFFC | off;
        endcase
      end
    endcase
  endfunction

  initial begin
    bus.MemWriteM  = 1'b0;
    bus.ALUResultM = A_CYCLE;
    bus.WriteDataM = 32'h0;
    bus.out_ready  = 1'b0;
    model_reset();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_cycle", bus.ReadDataM, 32'h0);
    check("rst_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst_data", {24'h0, bus.out_data}, 32'h0);
    check("rst_gpio", bus.gpio_out, 32'h0);
    bus.ALUResultM = A_TXSTAT;
    #1;
    check("rst_txstat", bus.ReadDataM, 32'h0000_0001);
    @(negedge clk);
    reset = 1'b0;

    // Cycle counter count and wrap
    for (int i = 0; i < 10; i++) step(1'b0, A_UNMAP, 32'h0, 1'b0, "idle");
    step(1'b0, A_CYCLE, 32'h0, 1'b0, "cyc");
    check("cyc10", last_rd, 32'd10);
    step(1'b1, A_CYCLE, 32'hFFFF_FFFE, 1'b0, "cycw");
    step(1'b0, A_CYCLE, 32'h0, 1'b0, "cyc");
    check("cyc_fffe", last_rd, 32'hFFFF_FFFE);
    step(1'b0, A_CYCLE, 32'h0, 1'b0, "cyc");
    check("cyc_ffff", last_rd, 32'hFFFF_FFFF);
    step(1'b0, A_CYCLE, 32'h0, 1'b0, "cyc");
    check("cyc_wrap", last_rd, 32'h0);

    // RAM write/read with ignored byte offset
    step(1'b1, 32'h0000_0014, 32'h1234_5678, 1'b0, "ramw");
    step(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, "ramw");
    step(1'b0, 32'h0000_0013, 32'h0, 1'b0, "ramr");
    check("ram_13", last_rd, 32'hDEAD_BEEF);
    step(1'b0, 32'h0000_0014, 32'h0, 1'b0, "ramr");
    check("ram_14", last_rd, 32'h1234_5678);

    // GPIO and unmapped writes
    step(1'b1, A_GPIO, 32'hA5A5_0001, 1'b0, "gpiow");
    step(1'b1, A_UNMAP, 32'hFFFF_FFFF, 1'b0, "unmw");
    step(1'b0, A_UNMAP, 32'h0, 1'b0, "unmr");
    check("unmap_rd", last_rd, 32'h0);
    check("gpio_keep", bus.gpio_out, 32'hA5A5_0001);

    // Overflow with out_ready held low, then drain
    for (int i = 0; i < 5; i++) step(1'b1, A_TXDATA, 32'(8'h11 + i), 1'b0, "push");
    step(1'b0, A_TXSTAT, 32'h0, 1'b0, "stat");
    check("txstat_ovf", last_rd, 32'h0000_0406);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, A_TXDATA, 32'h0, 1'b1, "drain");
      check("drain_seq", {24'h0, last_data}, 32'(8'h11 + i));
    end
    step(1'b0, A_TXDATA, 32'h0, 1'b1, "drain");
    check("drain_empty", {31'h0, last_valid}, 32'h0);

    // Push into a full FIFO while popping
    step(1'b1, A_TXSTAT, 32'h0, 1'b0, "clr");
    for (int i = 0; i < 4; i++) step(1'b1, A_TXDATA, 32'(8'h11 + i), 1'b0, "fill");
    step(1'b1, A_TXDATA, 32'h55, 1'b1, "pushpop");
    check("pushpop_head", {24'h0, last_data}, 32'h11);
    step(1'b0, A_TXSTAT, 32'h0, 1'b0, "stat");
    check("txstat_full", last_rd, 32'h0000_0402);
    for (int i = 0; i < 4; i++) step(1'b0, A_TXDATA, 32'h0, 1'b1, "drain2");
    check("last_55", {24'h0, last_data}, 32'h55);

    // Randomized traffic: mostly-stalled consumer, then mostly-ready consumer
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 1)), rand_addr(), $urandom(), $urandom_range(0, 3) == 0, "rndA");
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 1)), rand_addr(), $urandom(), $urandom_range(0, 3) != 0, "rndB");

    // Asynchronous reset between edges discards the FIFO immediately
    step(1'b1, A_TXSTAT, 32'h0, 1'b1, "clr2");
    for (int i = 0; i < 4; i++) step(1'b0, A_UNMAP, 32'h0, 1'b1, "flush");
    step(1'b1, A_TXDATA, 32'hA1, 1'b0, "p2");
    step(1'b1, A_TXDATA, 32'hA2, 1'b0, "p2");
    bus.MemWriteM  = 1'b0;
    bus.ALUResultM = A_TXSTAT;
    bus.out_ready  = 1'b0;
    #1;
    check("pre_arst_stat", bus.ReadDataM, 32'h0000_0200);
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    check("arst_valid", {31'h0, bus.out_valid}, 32'h0);
    check("arst_data", {24'h0, bus.out_data}, 32'h0);
    check("arst_stat", bus.ReadDataM, 32'h0000_0001);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++)
      step(1'($urandom_range(0, 1)), rand_addr(), $urandom(), 1'($urandom_range(0, 1)), "post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256: number of 32-bit RAM words, power of two.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output byte FIFO entries, power of two.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port MemWriteM  input  1  write strobe from the core memory stage.
REQ-006 SHALL have port ALUResultM  input  32  byte address of the access.
REQ-007 SHALL have port WriteDataM  input  32  store data.
REQ-008 SHALL have port ReadDataM  output  32  load data.
REQ-009 SHALL have port gpio_out  output  32  GPIO register value.
REQ-010 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port out_data  output  8  FIFO head byte.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the head byte.

Function
REQ-013 SHALL decode word accesses only; ALUResultM[1:0] SHALL be ignored.
REQ-014 SHALL map RAM at 0x0000_0000 to 4*RAM_WORDS-1, indexed by ALUResultM[log2(RAM_WORDS)+1:2].
REQ-015 SHALL map GPIO at 0x8000_0000, CYCLE at 0x8000_0004, TXDATA at 0x8000_0008, TXSTAT at 0x8000_000C.
REQ-016 SHALL return 0 on reads of unmapped addresses and SHALL ignore writes to them.
REQ-017 SHALL drive ReadDataM combinationally in the same cycle from the current address; no read latency.
REQ-018 SHALL commit a write on the rising edge where MemWriteM=1; the written value SHALL be readable from the next cycle.
REQ-019 GPIO SHALL be read/write; gpio_out SHALL equal the GPIO register.
REQ-020 CYCLE SHALL increment by 1 every cycle, wrapping 0xFFFF_FFFF to 0.
REQ-021 A write to CYCLE SHALL load WriteDataM, and the write SHALL take precedence over that cycle's increment.
REQ-022 A write to TXDATA SHALL push WriteDataM[7:0] into the FIFO; a read of TXDATA SHALL return {24'b0, head byte}, or 0 when empty.
REQ-023 TXSTAT read SHALL return {count in bits [15:8], 5'b0, overflow, full, empty}.
REQ-024 Any write to TXSTAT SHALL clear the sticky overflow bit.
REQ-025 A pop SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-026 out_valid SHALL be 1 iff the registered count is nonzero; out_data SHALL be the head entry, and 0 when empty.
REQ-027 A push into an empty FIFO SHALL raise out_valid one cycle later; same-cycle pass-through SHALL NOT occur.
REQ-028 A push while full and not popping SHALL be dropped and SHALL set overflow.
REQ-029 A push while full with a simultaneous pop SHALL be accepted; count SHALL stay FIFO_DEPTH and overflow SHALL be unchanged.
REQ-030 A simultaneous push and pop when not full SHALL leave count unchanged and preserve order.
REQ-031 Read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-032 While reset=1: GPIO=0, CYCLE=0, FIFO pointers and count=0, overflow=0, out_valid=0, out_data=0, gpio_out=0.
REQ-033 RAM contents SHALL NOT be reset; reads before the first write are undefined.
REQ-034 Reset asserted mid-operation SHALL discard FIFO contents immediately, without waiting for a clock edge.

Verification
REQ-035 Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0013 in the next cycle -> ReadDataM=0xDEADBEEF; read 0x0000_0014 returns the separately written word.
REQ-036 Release reset, idle 10 cycles, read CYCLE -> 10; write 0xFFFF_FFFE, then read on consecutive cycles -> 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
REQ-037 Hold out_ready=0 and push bytes 0x11..0x15 -> TXSTAT=0x0000_0406 (count 4, overflow, full); raise out_ready -> out_data sequence 0x11, 0x12, 0x13, 0x14, then out_valid=0.
REQ-038 Full FIFO, push 0x55 with out_ready=1 in the same cycle -> 0x11 popped, count stays 4, overflow stays 0, 0x55 emerges last.
REQ-039 Write GPIO=0xA5A5_0001, write 0x8000_0010, read 0x8000_0010 -> gpio_out=0xA5A5_0001 unchanged, read returns 0.
REQ-040 Push 2 bytes, assert reset asynchronously between clock edges -> out_valid=0, out_data=0, TXSTAT=0x0000_0001 immediately.
